// File: rtl/uart_irq_ctrl_if.sv
// Interrupt handshake and control bus between the UART interrupt controller
// and the system controller that services it.
interface uart_irq_ctrl_if #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned IDW   = $clog2(N_SRC)
);
    logic              irq;
    logic [IDW-1:0]    irq_id;
    logic              irq_ack;
    logic              mask_we;
    logic [N_SRC-1:0]  mask_wdata;
    logic              ovr_clr;

    // System controller side: services interrupts and programs the mask.
    modport master (
        input  irq,
        input  irq_id,
        output irq_ack,
        output mask_we,
        output mask_wdata,
        output ovr_clr
    );

    // Interrupt controller side.
    modport slave (
        output irq,
        output irq_id,
        input  irq_ack,
        input  mask_we,
        input  mask_wdata,
        input  ovr_clr
    );
endinterface

// File: rtl/uart_irq_ctrl.sv
// UART interrupt controller: captures per-source event pulses into sticky
// pending flags, masks them, and presents one source at a time to the system
// via a level irq / irq_ack handshake with round-robin fairness.
module uart_irq_ctrl #(
    parameter int unsigned       N_SRC    = 4,
    parameter int unsigned       IDW      = $clog2(N_SRC),
    parameter logic [N_SRC-1:0]  MASK_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SRC-1:0]  src_pulse,
    uart_irq_ctrl_if.slave    bus,
    output logic [N_SRC-1:0]  pending_q,
    output logic [N_SRC-1:0]  mask_q,
    output logic [N_SRC-1:0]  overrun
);

    typedef enum logic {
        IDLE,
        ASSERT
    } state_t;

    state_t            state_q, state_d;
    logic [N_SRC-1:0]  pending_d;
    logic [N_SRC-1:0]  mask_d;
    logic [N_SRC-1:0]  overrun_q, overrun_d;
    logic              irq_q, irq_d;
    logic [IDW-1:0]    irq_id_q, irq_id_d;
    logic [IDW-1:0]    last_grant_q, last_grant_d;

    logic [N_SRC-1:0]  eligible;
    logic [N_SRC-1:0]  clr_vec;
    logic              ack_accept;
    logic              sel_found;
    logic [IDW-1:0]    sel_idx;

    assign eligible   = pending_q & ~mask_q;
    assign ack_accept = (state_q == ASSERT) && bus.irq_ack;
    assign clr_vec    = ack_accept ? (N_SRC'(1) << irq_id_q) : '0;

    assign bus.irq    = irq_q;
    assign bus.irq_id = irq_id_q;
    assign overrun    = overrun_q;

    // Round-robin pick: first eligible source searching upward from last_grant+1.
    always_comb begin
        int unsigned    cand;
        logic [IDW-1:0] cand_idx;
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned off = 1; off <= N_SRC; off++) begin
            cand     = (32'(last_grant_q) + off) % N_SRC;
            cand_idx = IDW'(cand);
            if (!sel_found && eligible[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    // Pending/overrun/mask next state; a new pulse beats a same-cycle clear.
    always_comb begin
        pending_d = (pending_q & ~clr_vec) | src_pulse;
        overrun_d = (bus.ovr_clr ? '0 : overrun_q) | (src_pulse & pending_q);
        mask_d    = bus.mask_we ? bus.mask_wdata : mask_q;
    end

    // Source bookkeeping registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
            mask_q    <= MASK_RST;
            overrun_q <= '0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            overrun_q <= overrun_d;
        end
    end

    // FSM state register plus its registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            irq_q        <= 1'b0;
            irq_id_q     <= '0;
            last_grant_q <= IDW'(N_SRC - 1);
        end else begin
            state_q      <= state_d;
            irq_q        <= irq_d;
            irq_id_q     <= irq_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    // FSM next state: ack takes priority over withdraw-on-mask.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d = ASSERT;
                end
            end
            ASSERT: begin
                if (bus.irq_ack) begin
                    state_d = IDLE;
                end else if (mask_q[irq_id_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: irq follows the next state so it is registered with it.
    always_comb begin
        irq_d        = (state_d == ASSERT);
        irq_id_d     = irq_id_q;
        last_grant_d = last_grant_q;
        if ((state_q == IDLE) && (state_d == ASSERT)) begin
            irq_id_d = sel_idx;
        end
        if (ack_accept) begin
            last_grant_d = irq_id_q;
        end
    end

endmodule

// File: tb/tb_uart_irq_ctrl.sv
// Directed self-checking bench for uart_irq_ctrl with N_SRC=4.
module tb_uart_irq_ctrl;

    localparam int unsigned N_SRC = 4;
    localparam int unsigned IDW   = 2;

    logic              clk;
    logic              rst;
    logic [N_SRC-1:0]  src_pulse;
    logic [N_SRC-1:0]  pending_q;
    logic [N_SRC-1:0]  mask_q;
    logic [N_SRC-1:0]  overrun;

    int vectors;
    int miscompares;

    uart_irq_ctrl_if #(.N_SRC(N_SRC), .IDW(IDW)) bus ();

    uart_irq_ctrl #(.N_SRC(N_SRC), .IDW(IDW), .MASK_RST(4'b0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_pulse (src_pulse),
        .bus       (bus),
        .pending_q (pending_q),
        .mask_q    (mask_q),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        src_pulse      = '0;
        bus.irq_ack    = 1'b0;
        bus.mask_we    = 1'b0;
        bus.mask_wdata = '0;
        bus.ovr_clr    = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (bus.irq !== 1'b0 || bus.irq_id !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_irq: irq=%b id=%0d, expected irq=0 id=0", bus.irq, bus.irq_id);
        end
        vectors++;
        if (pending_q !== 4'b0000 || mask_q !== 4'b0000 || overrun !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_regs: pend=%b mask=%b ovr=%b, expected all 0", pending_q, mask_q, overrun);
        end
    endtask

    task automatic test_single();
        do_reset();
        src_pulse = 4'b0100;
        tick();
        src_pulse = '0;
        vectors++;
        if (pending_q !== 4'b0100 || bus.irq !== 1'b0) begin
            miscompares++;
            $display("FAIL single_pend: pend=%b irq=%b, expected pend=0100 irq=0", pending_q, bus.irq);
        end
        tick();
        vectors++;
        if (bus.irq !== 1'b1 || bus.irq_id !== 2'd2) begin
            miscompares++;
            $display("FAIL single_irq: irq=%b id=%0d, expected irq=1 id=2", bus.irq, bus.irq_id);
        end
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        vectors++;
        if (bus.irq !== 1'b0 || pending_q !== 4'b0000) begin
            miscompares++;
            $display("FAIL single_ack: irq=%b pend=%b, expected irq=0 pend=0000", bus.irq, pending_q);
        end
    endtask

    task automatic test_round_robin();
        logic [IDW-1:0] exp_order [5];
        logic [N_SRC-1:0] exp_pend [5];
        exp_order = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1};
        exp_pend  = '{4'b1010, 4'b1000, 4'b0000, 4'b0010, 4'b0000};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                src_pulse = 4'b1011;
                tick();
                src_pulse = '0;
            end else if (k == 3) begin
                src_pulse = 4'b0011;
                tick();
                src_pulse = '0;
            end
            tick();
            vectors++;
            if (bus.irq !== 1'b1 || bus.irq_id !== exp_order[k]) begin
                miscompares++;
                $display("FAIL rr_grant%0d: irq=%b id=%0d, expected irq=1 id=%0d", k, bus.irq, bus.irq_id, exp_order[k]);
            end
            bus.irq_ack = 1'b1;
            tick();
            bus.irq_ack = 1'b0;
            vectors++;
            if (bus.irq !== 1'b0 || pending_q !== exp_pend[k]) begin
                miscompares++;
                $display("FAIL rr_gap%0d: irq=%b pend=%b, expected irq=0 pend=%b", k, bus.irq, pending_q, exp_pend[k]);
            end
        end
    endtask

    task automatic test_set_wins();
        do_reset();
        src_pulse = 4'b0010;
        tick();
        src_pulse = '0;
        tick();
        vectors++;
        if (bus.irq !== 1'b1 || bus.irq_id !== 2'd1) begin
            miscompares++;
            $display("FAIL setwins_irq: irq=%b id=%0d, expected irq=1 id=1", bus.irq, bus.irq_id);
        end
        bus.irq_ack = 1'b1;
        src_pulse   = 4'b0010;
        tick();
        bus.irq_ack = 1'b0;
        src_pulse   = '0;
        vectors++;
        if (pending_q !== 4'b0010 || overrun !== 4'b0010 || bus.irq !== 1'b0) begin
            miscompares++;
            $display("FAIL setwins_pend: pend=%b ovr=%b irq=%b, expected pend=0010 ovr=0010 irq=0", pending_q, overrun, bus.irq);
        end
        tick();
        vectors++;
        if (bus.irq !== 1'b1 || bus.irq_id !== 2'd1) begin
            miscompares++;
            $display("FAIL setwins_reassert: irq=%b id=%0d, expected irq=1 id=1", bus.irq, bus.irq_id);
        end
        bus.ovr_clr = 1'b1;
        tick();
        bus.ovr_clr = 1'b0;
        vectors++;
        if (overrun !== 4'b0000) begin
            miscompares++;
            $display("FAIL ovr_clr: ovr=%b, expected 0000", overrun);
        end
    endtask

    task automatic test_mask();
        do_reset();
        bus.mask_we    = 1'b1;
        bus.mask_wdata = 4'b0001;
        tick();
        bus.mask_we    = 1'b0;
        vectors++;
        if (mask_q !== 4'b0001) begin
            miscompares++;
            $display("FAIL mask_write: mask=%b, expected 0001", mask_q);
        end
        src_pulse = 4'b0001;
        tick();
        src_pulse = '0;
        tick();
        tick();
        vectors++;
        if (pending_q !== 4'b0001 || bus.irq !== 1'b0) begin
            miscompares++;
            $display("FAIL mask_block: pend=%b irq=%b, expected pend=0001 irq=0", pending_q, bus.irq);
        end
        bus.mask_we    = 1'b1;
        bus.mask_wdata = 4'b0000;
        tick();
        bus.mask_we    = 1'b0;
        vectors++;
        if (bus.irq !== 1'b0) begin
            miscompares++;
            $display("FAIL mask_unmask_early: irq=%b, expected 0", bus.irq);
        end
        tick();
        vectors++;
        if (bus.irq !== 1'b1 || bus.irq_id !== 2'd0) begin
            miscompares++;
            $display("FAIL mask_unmask: irq=%b id=%0d, expected irq=1 id=0", bus.irq, bus.irq_id);
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        src_pulse = 4'b0100;
        tick();
        src_pulse = '0;
        tick();
        vectors++;
        if (bus.irq !== 1'b1 || bus.irq_id !== 2'd2) begin
            miscompares++;
            $display("FAIL wd_irq: irq=%b id=%0d, expected irq=1 id=2", bus.irq, bus.irq_id);
        end
        src_pulse = 4'b1000;
        tick();
        src_pulse      = '0;
        bus.mask_we    = 1'b1;
        bus.mask_wdata = 4'b0100;
        tick();
        bus.mask_we    = 1'b0;
        tick();
        vectors++;
        if (bus.irq !== 1'b0 || pending_q !== 4'b1100) begin
            miscompares++;
            $display("FAIL wd_drop: irq=%b pend=%b, expected irq=0 pend=1100", bus.irq, pending_q);
        end
        tick();
        vectors++;
        if (bus.irq !== 1'b1 || bus.irq_id !== 2'd3) begin
            miscompares++;
            $display("FAIL wd_switch: irq=%b id=%0d, expected irq=1 id=3", bus.irq, bus.irq_id);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        src_pulse = 4'b0011;
        tick();
        src_pulse = 4'b0001;
        tick();
        src_pulse = '0;
        vectors++;
        if (bus.irq !== 1'b1 || bus.irq_id !== 2'd0 || overrun !== 4'b0001) begin
            miscompares++;
            $display("FAIL ar_setup: irq=%b id=%0d ovr=%b, expected irq=1 id=0 ovr=0001", bus.irq, bus.irq_id, overrun);
        end
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.irq !== 1'b0 || pending_q !== 4'b0000 || overrun !== 4'b0000) begin
            miscompares++;
            $display("FAIL ar_immediate: irq=%b pend=%b ovr=%b, expected all 0", bus.irq, pending_q, overrun);
        end
        tick();
        #2;
        rst = 1'b1;
        tick();
        tick();
        tick();
        vectors++;
        if (bus.irq !== 1'b0) begin
            miscompares++;
            $display("FAIL ar_quiet: irq=%b, expected 0", bus.irq);
        end
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        tick();
        vectors++;
        if (bus.irq !== 1'b0 || pending_q !== 4'b0000) begin
            miscompares++;
            $display("FAIL ar_stray_ack: irq=%b pend=%b, expected irq=0 pend=0000", bus.irq, pending_q);
        end
        src_pulse = 4'b1000;
        tick();
        src_pulse = '0;
        tick();
        vectors++;
        if (bus.irq !== 1'b1 || bus.irq_id !== 2'd3) begin
            miscompares++;
            $display("FAIL ar_new_irq: irq=%b id=%0d, expected irq=1 id=3", bus.irq, bus.irq_id);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_set_wins();
        test_mask();
        test_withdraw();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_irq_ctrl.md
Name: uart_irq_ctrl

Overview:
- Interrupt controller for the UART subsystem.
- Captures single-cycle event pulses from N_SRC sources (rx done, tx done, parity error, framing error) into sticky pending flags, and applies a per-source mask.
- Round-robin arbitrates among enabled pending sources and presents one interrupt at a time to the system controller via an irq/ack handshake.
- Replaces the single-flag interrupt register per source with one shared, sequenced interrupt path.

Parameters:
- N_SRC, 4, number of interrupt sources (2..16).
- IDW, $clog2(N_SRC), width of irq_id.
- MASK_RST, {N_SRC{1'b0}}, reset value of mask register (1 = source disabled).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- src_pulse  in  N_SRC  event pulses, one bit per source, sampled each clk.
- mask_we  in  1  mask register write strobe.
- mask_wdata  in  N_SRC  new mask value (1 = disable source).
- irq_ack  in  1  system acknowledges the currently presented interrupt.
- ovr_clr  in  1  clears all overrun flags.
- irq  out  1  interrupt request, level, registered.
- irq_id  out  IDW  index of the presented source; valid while irq=1.
- pending_q  out  N_SRC  current pending flags.
- mask_q  out  N_SRC  current mask register.
- overrun  out  N_SRC  sticky flag: an event arrived while that source was already pending.

Behaviour:
- Reset (rst=0, async): pending_q=0, mask_q=MASK_RST, overrun=0, irq=0, irq_id=0, FSM=IDLE, last_grant=N_SRC-1 (so the first search starts at source 0).
- Pending flags:
  - pending[i] is set on the clk edge after src_pulse[i]=1.
  - pending[i] is cleared on an accepted ack for i.
  - If src_pulse[i] and the clear coincide, set wins: pending[i] stays 1.
  - Otherwise the flag holds.
- Overrun: overrun[i] is set when src_pulse[i]=1 while pending[i]=1, evaluated before any same-cycle clear. ovr_clr clears all bits next edge; a simultaneous new overrun wins for its bit.
- Mask: mask_q <= mask_wdata on the edge where mask_we=1. Masked sources still capture pending and overrun but are not arbitrated.
- eligible = pending_q & ~mask_q.
- FSM states:
  - IDLE:
    - irq=0.
    - If eligible != 0: select the first eligible index searching upward (mod N_SRC) from last_grant+1, register it into irq_id, set irq=1, go to ASSERT.
    - Otherwise stay in IDLE.
    - irq_ack is ignored in IDLE.
  - ASSERT: irq=1 and irq_id is held stable.
    - On irq_ack=1: clear pending[irq_id] (subject to the set-wins rule), last_grant<=irq_id, irq<=0, go to IDLE.
    - Else, if mask_q[irq_id]=1 (source masked after grant): irq<=0, pending is retained, last_grant is unchanged, go to IDLE (withdraw).
    - Else stay in ASSERT.
- Latency:
  - src_pulse at edge t -> pending at t+1 -> irq=1 at t+2.
  - ack sampled at edge a -> irq=0 at a+1.
  - The earliest next irq is a+2, so irq is low for at least one cycle between interrupts.
- Width rules: the round-robin index wraps modulo N_SRC. irq_id values >= N_SRC are never produced.
- Reset mid-operation: everything returns to reset values immediately, and no ack is required afterwards.

Test Plan:
1. Reset with N_SRC=4. Pulse src_pulse=4'b0100 for one cycle -> pending_q=4'b0100 one cycle later, irq=1 with irq_id=2 two cycles after the pulse. Pulse irq_ack -> irq=0 and pending_q=0 next cycle.
2. Round-robin: pulse src_pulse=4'b1011 together; ack each grant -> grant order is 0,1,3. Then pulse 4'b0011 -> order is 0,1 (last_grant=3 wraps to 0). irq is low for at least 1 cycle between grants.
3. Set-wins/overrun: while irq_id=1 is presented, pulse src_pulse[1] in the same cycle as irq_ack -> pending_q[1] stays 1, overrun[1]=1, irq reasserts with irq_id=1. ovr_clr -> overrun=0.
4. Mask: write mask 4'b0001, then pulse src 0 -> pending_q[0]=1 and irq stays 0. Write mask 4'b0000 -> irq=1 with irq_id=0 two cycles after the write edge.
5. Withdraw: while irq_id=2 is asserted, write mask 4'b0100 -> irq=0 next cycle, pending_q[2] stays 1. With pending_q=4'b1100, grant switches to source 3.
6. Async reset: assert rst low mid-ASSERT, between clk edges -> irq, pending_q and overrun go to 0 immediately; after release, no irq appears until a new pulse. A stray irq_ack in IDLE has no effect.
